// File: rtl/tile_game_pkg.sv
// Shared definitions for the tile matching game: turn states, top-level mode
// encodings and default board geometry.
package tile_game_pkg;

   localparam int NUM_TILES_DEF = 10;
   localparam int ID_W_DEF      = 3;
   localparam int IDX_W         = 4;
   localparam int TURN_W        = 3;

   typedef enum logic [TURN_W-1:0] {
      S_OFF  = 3'd0,
      S_IDLE = 3'd1,
      S_ONE  = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4
   } turnState_t;

   localparam logic [3:0] MODE_MENU        = 4'b0000;
   localparam logic [3:0] MODE_INGAME      = 4'b0011;
   localparam logic [3:0] MODE_ENDGAME     = 4'b0101;
   localparam logic [3:0] MODE_LEADERBOARD = 4'b1001;

endpackage

// File: rtl/tile_turn_controller_sw_select_detect.sv
// Turns switch rising edges into a single tile selection; a cycle with more
// than one rising edge produces no selection.
module sw_select_detect
   import tile_game_pkg::*;
#(
   parameter int NUM_TILES = NUM_TILES_DEF
) (
   input  logic                 CLOCK_50,
   input  logic                 resetn,
   input  logic [NUM_TILES-1:0] sw,
   output logic                 sel_valid,
   output logic [IDX_W-1:0]     sel_idx
);

   logic [NUM_TILES-1:0] swPrev;
   logic [NUM_TILES-1:0] rise;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) swPrev <= '0;
      else         swPrev <= sw;
   end

   assign rise = sw & ~swPrev;

   // Clearing the lowest set bit leaves zero exactly when one bit was set.
   assign sel_valid = (rise != '0) && ((rise & (rise - NUM_TILES'(1))) == '0);

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (rise[i]) sel_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/tile_turn_controller.sv
// Runs one game of tile matching: selection, reveal hold, pair resolution,
// move counting and end-of-game detection.
module tile_turn_controller
   import tile_game_pkg::*;
#(
   parameter int NUM_TILES   = NUM_TILES_DEF,
   parameter int ID_W        = ID_W_DEF,
   parameter int SHOW_CYCLES = 25000000,
   parameter int MOVES_W     = 8
) (
   input  logic                      CLOCK_50,
   input  logic                      resetn,
   input  logic                      start,
   input  logic                      quit,
   input  logic [NUM_TILES-1:0]      sw,
   input  logic [NUM_TILES*ID_W-1:0] layout,
   output logic [NUM_TILES-1:0]      face_up,
   output logic [NUM_TILES-1:0]      matched,
   output logic [MOVES_W-1:0]        moves,
   output logic                      all_matched,
   output logic [TURN_W-1:0]         turn_state
);

   // state  | meaning
   // S_OFF  | not in game; waits for start
   // S_IDLE | no tile revealed this turn
   // S_ONE  | first tile revealed, waiting for second
   // S_HOLD | pair revealed, hold counter running
   // S_DONE | every pair matched, waits for quit or start

   localparam int CNT_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam int PAIR_W = $clog2(NUM_TILES/2 + 1);

   turnState_t                state, stateNext;
   logic [NUM_TILES*ID_W-1:0] layoutReg, layoutNext;
   logic [NUM_TILES-1:0]      faceUpNext, matchedNext;
   logic [MOVES_W-1:0]        movesNext;
   logic                      allMatchedNext;
   logic [IDX_W-1:0]          firstIdx, firstNext, secondIdx, secondNext;
   logic [CNT_W-1:0]          holdCnt, holdNext;
   logic [PAIR_W-1:0]         pairCount, pairNext;
   logic                      selValid, selFree;
   logic [IDX_W-1:0]          selIdx;
   logic [ID_W-1:0]           idFirst, idSecond;

   sw_select_detect #(.NUM_TILES(NUM_TILES)) uSelect (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .sw        (sw),
      .sel_valid (selValid),
      .sel_idx   (selIdx)
   );

   assign selFree  = selValid && !face_up[selIdx] && !matched[selIdx];
   assign idFirst  = layoutReg[firstIdx*ID_W +: ID_W];
   assign idSecond = layoutReg[secondIdx*ID_W +: ID_W];

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state       <= S_OFF;
         layoutReg   <= '0;
         face_up     <= '0;
         matched     <= '0;
         moves       <= '0;
         all_matched <= 1'b0;
         firstIdx    <= '0;
         secondIdx   <= '0;
         holdCnt     <= '0;
         pairCount   <= '0;
      end else begin
         state       <= stateNext;
         layoutReg   <= layoutNext;
         face_up     <= faceUpNext;
         matched     <= matchedNext;
         moves       <= movesNext;
         all_matched <= allMatchedNext;
         firstIdx    <= firstNext;
         secondIdx   <= secondNext;
         holdCnt     <= holdNext;
         pairCount   <= pairNext;
      end
   end

   always_comb begin
      stateNext      = state;
      layoutNext     = layoutReg;
      faceUpNext     = face_up;
      matchedNext    = matched;
      movesNext      = moves;
      allMatchedNext = all_matched;
      firstNext      = firstIdx;
      secondNext     = secondIdx;
      holdNext       = holdCnt;
      pairNext       = pairCount;

      if (quit) begin
         // matched and moves stay up so the display can show the abandoned game
         if (state != S_OFF) begin
            stateNext      = S_OFF;
            faceUpNext     = '0;
            allMatchedNext = 1'b0;
         end
      end else if (start) begin
         stateNext      = S_IDLE;
         layoutNext     = layout;
         faceUpNext     = '0;
         matchedNext    = '0;
         movesNext      = '0;
         allMatchedNext = 1'b0;
         pairNext       = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (selFree) begin
                  faceUpNext[selIdx] = 1'b1;
                  firstNext          = selIdx;
                  stateNext          = S_ONE;
               end
            end
            S_ONE: begin
               if (selFree) begin
                  faceUpNext[selIdx] = 1'b1;
                  secondNext         = selIdx;
                  if (moves != '1) movesNext = moves + MOVES_W'(1);
                  holdNext  = CNT_W'(SHOW_CYCLES - 1);
                  stateNext = S_HOLD;
               end
            end
            S_HOLD: begin
               if (holdCnt == '0) begin
                  faceUpNext[firstIdx]  = 1'b0;
                  faceUpNext[secondIdx] = 1'b0;
                  if (idFirst == idSecond) begin
                     matchedNext[firstIdx]  = 1'b1;
                     matchedNext[secondIdx] = 1'b1;
                     pairNext = pairCount + PAIR_W'(1);
                  end
                  if (pairNext == PAIR_W'(NUM_TILES/2)) begin
                     stateNext      = S_DONE;
                     allMatchedNext = 1'b1;
                  end else begin
                     stateNext = S_IDLE;
                  end
               end else begin
                  holdNext = holdCnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign turn_state = state;

endmodule

// File: tb/tb_tile_turn_controller.sv
// Directed bench for tile_turn_controller with a short reveal hold.
module tb_tile_turn_controller;
   import tile_game_pkg::*;

   localparam int NT = 10;
   localparam int IW = 3;
   localparam int SC = 4;
   localparam int MW = 8;

   logic              CLOCK_50 = 1'b0;
   logic              resetn   = 1'b0;
   logic              start    = 1'b0;
   logic              quit     = 1'b0;
   logic [NT-1:0]     sw       = '0;
   logic [NT*IW-1:0]  layout;
   logic [NT-1:0]     face_up, matched;
   logic [MW-1:0]     moves;
   logic              all_matched;
   logic [TURN_W-1:0] turn_state;

   int checkCount = 0;
   int passCount  = 0;

   tile_turn_controller #(
      .NUM_TILES(NT), .ID_W(IW), .SHOW_CYCLES(SC), .MOVES_W(MW)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .start       (start),
      .quit        (quit),
      .sw          (sw),
      .layout      (layout),
      .face_up     (face_up),
      .matched     (matched),
      .moves       (moves),
      .all_matched (all_matched),
      .turn_state  (turn_state)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic pick(input int idx);
      sw[idx] = 1'b1;
      tick();
      sw[idx] = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic playPair(input int a, input int b);
      pick(a);
      pick(b);
      tick(SC);
   endtask

   initial begin
      // ids 0,1,2,3,4,0,1,2,3,4 for tiles 0..9
      for (int i = 0; i < NT; i++) layout[i*IW +: IW] = IW'(i % 5);

      #12;
      checkVal("rst_face_up", 32'(face_up), 32'h0);
      checkVal("rst_matched", 32'(matched), 32'h0);
      checkVal("rst_moves", 32'(moves), 32'h0);
      checkVal("rst_state", 32'(turn_state), 32'd0);
      resetn = 1'b1;
      tick();

      pulseStart();
      checkVal("start_state", 32'(turn_state), 32'd1);

      pick(0);
      checkVal("first_face_up", 32'(face_up), 32'h001);
      checkVal("first_state", 32'(turn_state), 32'd2);
      checkVal("first_moves", 32'(moves), 32'd0);

      sw[5] = 1'b1;
      for (int c = 0; c < SC; c++) begin
         tick();
         checkVal($sformatf("hold%0d_face_up", c), 32'(face_up), 32'h021);
         checkVal($sformatf("hold%0d_moves", c), 32'(moves), 32'd1);
      end
      tick();
      checkVal("match_matched", 32'(matched), 32'h021);
      checkVal("match_face_up", 32'(face_up), 32'h0);
      checkVal("match_state", 32'(turn_state), 32'd1);

      // mismatch 1/2 with a switch raised mid-hold
      sw[1] = 1'b1;
      tick();
      sw[2] = 1'b1;
      tick();
      checkVal("mis_moves", 32'(moves), 32'd2);
      sw[3] = 1'b1;
      tick();
      checkVal("hold_sw3_face_up", 32'(face_up), 32'h006);
      checkVal("hold_sw3_state", 32'(turn_state), 32'd3);
      tick(SC - 1);
      checkVal("mis_face_up", 32'(face_up), 32'h0);
      checkVal("mis_matched", 32'(matched), 32'h021);
      checkVal("mis_state", 32'(turn_state), 32'd1);

      sw[3] = 1'b0;
      tick();
      sw[3] = 1'b1;
      sw[4] = 1'b1;
      tick();
      checkVal("double_face_up", 32'(face_up), 32'h0);
      checkVal("double_state", 32'(turn_state), 32'd1);

      sw[5] = 1'b0;
      tick();
      sw[5] = 1'b1;
      tick();
      checkVal("matched_sel_face_up", 32'(face_up), 32'h0);
      checkVal("matched_sel_state", 32'(turn_state), 32'd1);

      sw = '0;
      tick();
      playPair(1, 6);
      checkVal("pair16_matched", 32'(matched), 32'h063);
      playPair(2, 7);
      playPair(3, 8);
      checkVal("mid_all_matched", 32'(all_matched), 32'd0);
      playPair(4, 9);
      checkVal("done_all_matched", 32'(all_matched), 32'd1);
      checkVal("done_state", 32'(turn_state), 32'd4);
      checkVal("done_matched", 32'(matched), 32'h3FF);
      checkVal("done_moves", 32'(moves), 32'd6);
      pick(0);
      checkVal("done_sel_state", 32'(turn_state), 32'd4);

      pulseStart();
      checkVal("restart_face_up", 32'(face_up), 32'h0);
      checkVal("restart_matched", 32'(matched), 32'h0);
      checkVal("restart_moves", 32'(moves), 32'd0);
      checkVal("restart_all_matched", 32'(all_matched), 32'd0);
      checkVal("restart_state", 32'(turn_state), 32'd1);

      // quit while one tile is revealed
      playPair(0, 5);
      pick(1);
      checkVal("pre_quit_face_up", 32'(face_up), 32'h002);
      quit = 1'b1;
      tick();
      quit = 1'b0;
      checkVal("quit_state", 32'(turn_state), 32'd0);
      checkVal("quit_face_up", 32'(face_up), 32'h0);
      checkVal("quit_moves", 32'(moves), 32'd1);
      checkVal("quit_matched", 32'(matched), 32'h021);
      pick(2);
      checkVal("off_sel_face_up", 32'(face_up), 32'h0);

      // async reset in the middle of a hold
      pulseStart();
      pick(1);
      pick(6);
      tick();
      checkVal("pre_rst_state", 32'(turn_state), 32'd3);
      #2 resetn = 1'b0;
      #1;
      checkVal("arst_face_up", 32'(face_up), 32'h0);
      checkVal("arst_matched", 32'(matched), 32'h0);
      checkVal("arst_moves", 32'(moves), 32'd0);
      checkVal("arst_all_matched", 32'(all_matched), 32'd0);
      checkVal("arst_state", 32'(turn_state), 32'd0);
      #10 resetn = 1'b1;
      tick(2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tile_turn_controller.md
Name: tile_turn_controller

Overview:
- Sequences one game of tile matching while the top-level mode FSM is in the in-game mode.
- Converts switch flips into tile selections and tracks the idle / one-tile / two-tile turn flow.
- Holds a revealed pair for a fixed time, then resolves it as matched or flipped back.
- Counts moves for the score and raises all_matched, which the mode FSM uses to enter end-game.

Parameters:
- NUM_TILES, 10: number of tiles; one switch per tile; must be even.
- ID_W, 3: width of each tile's face identifier.
- SHOW_CYCLES, 25000000: reveal hold length in clock cycles (0.5 s at 50 MHz).
- MOVES_W, 8: width of the move counter.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse from the mode FSM on entry to in-game; clears and arms the board.
- quit  in  1  level; abandons the game.
- sw  in  NUM_TILES  tile-select switches, already synchronized upstream; no debounce in this block.
- layout  in  NUM_TILES*ID_W  face id per tile; tile i occupies bits [i*ID_W +: ID_W]; sampled only on accepted start.
- face_up  out  NUM_TILES  tiles currently revealed and not yet resolved.
- matched  out  NUM_TILES  tiles permanently matched.
- moves  out  MOVES_W  completed pair attempts.
- all_matched  out  1  every pair matched; the game is done.
- turn_state  out  3  current state encoding, for the VGA/HEX display.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state = S_OFF.
  - face_up, matched, moves, all_matched all 0.
  - Layout register, first/second index and hold counter all 0.
- Selection event:
  - Rising edge of sw[i], detected against last cycle's registered sw.
  - If more than one switch rises in the same cycle, the whole cycle is ignored.
  - A selection is valid only if the tile is neither face_up nor matched.
  - Falling edges are always ignored.
- States: S_OFF, S_IDLE, S_ONE, S_HOLD, S_DONE.
- Priority each cycle: quit, then start, then normal transitions.
- quit=1 in any state other than S_OFF:
  - Next state is S_OFF; face_up cleared; all_matched cleared.
  - matched and moves hold their values for display.
- start in any state (when quit=0):
  - Latch layout; clear face_up, matched, moves, all_matched and the pair count.
  - Next state is S_IDLE.
- S_IDLE: on a valid selection i, set face_up[i], first=i, and go to S_ONE.
- S_ONE: on a valid selection j, set face_up[j] and second=j.
  - moves increments by 1 and saturates at all-ones; it never wraps.
  - Load hold counter with SHOW_CYCLES-1 and go to S_HOLD.
  - Reselecting the first tile is invalid, because it is face_up.
- S_HOLD:
  - All selections are ignored, and switch edges seen during the hold are discarded.
  - The counter decrements each cycle.
  - In the cycle the counter equals 0, resolve the pair:
    - If layout ids of first and second are equal, set matched[first] and matched[second] and increment the pair count.
    - In both cases, clear face_up for both tiles.
    - If the new pair count equals NUM_TILES/2, go to S_DONE and set all_matched=1; otherwise go to S_IDLE.
- S_DONE: all_matched stays 1 and selections are ignored until quit or start.
- Timing:
  - Outputs are registered; a selection accepted in cycle t is visible on face_up in cycle t+1.
  - The pair is visible for exactly SHOW_CYCLES cycles after the second tile appears.
  - Resolution is visible at t+1+SHOW_CYCLES.
- Layout content is not checked. Equal ids are always a match, even when an id appears more than twice.
- turn_state encoding: S_OFF=0, S_IDLE=1, S_ONE=2, S_HOLD=3, S_DONE=4.

Decomposition:
- Shared package tile_game_pkg holds:
  - Turn state localparams.
  - Mode encodings used by the top FSM: menu 4'b0000, ingame 4'b0011, endgame 4'b0101, leaderboard 4'b1001.
  - NUM_TILES and ID_W defaults.
- One sub-module, sw_select_detect: registers sw and outputs sel_valid plus sel_idx (4 bits), with sel_valid=1 only when exactly one rising edge occurs. Masking by face_up/matched stays in the controller.

Test Plan (SHOW_CYCLES=4, layout ids 0,1,2,3,4,0,1,2,3,4 for tiles 0..9):
- Reset, then start, then raise sw[0]: face_up=10'h001, turn_state=2, moves=0.
- Then raise sw[5]:
  - face_up=10'h021 and moves=1 for 4 cycles.
  - Next cycle: matched=10'h021, face_up=0, turn_state=1.
- Raise sw[1], then sw[2] (ids 1 and 2): moves=2; after the hold, face_up=0 and matched unchanged.
- Raise sw[3] and sw[4] in the same cycle: no change. Raise sw[5] (already matched): no change.
- Also check that raising sw[3] during S_HOLD is ignored.
- Play pairs (1,6), (2,7), (3,8), (4,9) after the first match:
  - all_matched=1 and turn_state=4.
  - Then pulse start: all outputs return to 0 and turn_state=1.
- In S_ONE with face_up=10'h001:
  - Assert quit: turn_state=0, face_up=0, moves retained.
  - Separately, assert resetn=0 mid-S_HOLD: all outputs go to 0 immediately, without waiting for a clock edge.
